// File: rtl/tile_seq_pkg.sv
// Shared types and constants for the tile select sequencer.
package tile_seq_pkg;

  typedef enum logic [1:0] {
    ST_DRAIN   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_PARK    = 2'd3
  } state_t;

  // Wide enough for any SEL_W; callers take the low SEL_W bits.
  localparam logic [15:0] PARK_CODE = 16'hFFFF;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/tile_select_sequencer_sel_debounce.sv
// Two-flop synchroniser followed by a stability counter on the pad select.
module sel_debounce
  import tile_seq_pkg::*;
#(
  parameter int               SEL_W      = 2,
  parameter int               STABLE_CYC = 4,
  parameter logic [SEL_W-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] i_sel,
  output logic [SEL_W-1:0] o_sel_stable
);

  localparam int            CW   = cnt_width(STABLE_CYC, 1, 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYC - 1);

  logic [SEL_W-1:0] r_sync1;
  logic [SEL_W-1:0] r_sync2;
  logic [SEL_W-1:0] r_stable;
  logic [CW-1:0]    r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= i_sel;
      r_sync2 <= r_sync1;
    end
  end

  // r_sync1 != r_sync2 means the synced value is about to move, so the run restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable <= RESET_VAL;
      r_cnt    <= '0;
    end else if ((r_sync1 != r_sync2) || (r_sync2 == r_stable)) begin
      r_cnt <= '0;
    end else if (r_cnt >= LAST) begin
      r_stable <= r_sync2;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sel_stable = r_stable;

endmodule

// File: rtl/tile_select_sequencer.sv
// Selects one of NUM_TILES tiles and sequences gate/reset/release/settle on every switch.
//   state   | meaning
//   DRAIN   | all tiles gated and in reset for RST_CYC cycles
//   RELEASE | only the target tile enabled, settling for SETTLE_CYC cycles
//   RUN     | target tile output registered onto uo_out
//   PARK    | invalid select; everything off
module tile_select_sequencer
  import tile_seq_pkg::*;
#(
  parameter int NUM_TILES    = 4,
  parameter int SEL_W        = 2,
  parameter int DEFAULT_TILE = 0,
  parameter int STABLE_CYC   = 4,
  parameter int RST_CYC      = 8,
  parameter int SETTLE_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel_in,
  input  logic                   hold,
  input  logic [NUM_TILES*8-1:0] tile_uo,
  output logic [NUM_TILES-1:0]   tile_rst_n,
  output logic [NUM_TILES-1:0]   tile_ena,
  output logic [7:0]             uo_out,
  output logic [SEL_W-1:0]       sel_active,
  output logic                   busy
);

  localparam int               CNT_W    = cnt_width(RST_CYC, SETTLE_CYC, STABLE_CYC);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1);
  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_TILE);
  localparam logic [SEL_W-1:0] PARK_SEL = PARK_CODE[SEL_W-1:0];

  state_t               r_state;
  logic [SEL_W-1:0]     r_tgt;
  logic [CNT_W-1:0]     r_cnt;
  logic [SEL_W-1:0]     r_sel_active;
  logic [NUM_TILES-1:0] r_ena;
  logic [NUM_TILES-1:0] r_rst_n;
  logic [7:0]           r_uo;
  logic                 r_busy;

  state_t               w_state_nxt;
  logic [SEL_W-1:0]     w_tgt_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [SEL_W-1:0]     w_sel_active_nxt;
  logic [7:0]           w_uo_nxt;
  logic [SEL_W-1:0]     w_sel_stable;
  logic                 w_sel_valid;
  logic [7:0]           w_tile_byte;
  logic [NUM_TILES-1:0] w_onehot;
  logic                 w_drive;

  sel_debounce #(
    .SEL_W      (SEL_W),
    .STABLE_CYC (STABLE_CYC),
    .RESET_VAL  (DEF_SEL)
  ) u_sel_debounce (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sel        (sel_in),
    .o_sel_stable (w_sel_stable)
  );

  assign w_sel_valid = (32'(w_sel_stable) < NUM_TILES);

  // Explicit mux keeps an out-of-range sel_active from indexing past tile_uo.
  always_comb begin
    w_tile_byte = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      if (r_sel_active == SEL_W'(i)) w_tile_byte = tile_uo[i*8 +: 8];
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_tgt_nxt        = r_tgt;
    w_cnt_nxt        = r_cnt;
    w_sel_active_nxt = r_sel_active;
    w_uo_nxt         = r_uo;
    case (r_state)
      ST_DRAIN: begin
        // Target follows the select without restarting the drain count.
        w_tgt_nxt = w_sel_stable;
        w_uo_nxt  = '0;
        if (r_cnt >= RST_LAST) begin
          w_cnt_nxt = '0;
          if (w_sel_valid) begin
            w_state_nxt      = ST_RELEASE;
            w_sel_active_nxt = w_sel_stable;
          end else begin
            w_state_nxt      = ST_PARK;
            w_sel_active_nxt = PARK_SEL;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        w_uo_nxt = '0;
        if (w_sel_stable != r_tgt) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
          w_tgt_nxt   = w_sel_stable;
        end else if (r_cnt >= SET_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (w_sel_stable != r_sel_active) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
          w_tgt_nxt   = w_sel_stable;
          w_uo_nxt    = '0;
        end else if (!hold) begin
          w_uo_nxt = w_tile_byte;
        end
      end
      ST_PARK: begin
        w_uo_nxt = '0;
        if (w_sel_valid) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = '0;
          w_tgt_nxt   = w_sel_stable;
        end
      end
      default: begin
        w_state_nxt = ST_DRAIN;
        w_cnt_nxt   = '0;
        w_uo_nxt    = '0;
      end
    endcase
  end

  // Tile controls are registered from the next state so they line up with it.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_TILES; i++) begin
      w_onehot[i] = (w_tgt_nxt == SEL_W'(i));
    end
  end

  assign w_drive = (w_state_nxt == ST_RELEASE) || (w_state_nxt == ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_DRAIN;
      r_tgt        <= DEF_SEL;
      r_cnt        <= '0;
      r_sel_active <= DEF_SEL;
      r_ena        <= '0;
      r_rst_n      <= '0;
      r_uo         <= '0;
      r_busy       <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_tgt        <= w_tgt_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel_active <= w_sel_active_nxt;
      r_ena        <= w_drive ? w_onehot : '0;
      r_rst_n      <= w_drive ? w_onehot : '0;
      r_uo         <= w_uo_nxt;
      r_busy       <= (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_RELEASE);
    end
  end

  assign tile_ena   = r_ena;
  assign tile_rst_n = r_rst_n;
  assign uo_out     = r_uo;
  assign sel_active = r_sel_active;
  assign busy       = r_busy;

endmodule

// File: tb/tb_tile_select_sequencer.sv
// Checks a 4-tile and a 3-tile sequencer against a phase/remaining-cycles model.
module tb_tile_select_sequencer;

  localparam int STABLE_CYC = 4;
  localparam int RST_CYC    = 8;
  localparam int SETTLE_CYC = 2;
  localparam int DB_WIN     = STABLE_CYC + 1;
  localparam int PH_DRAIN = 0, PH_REL = 1, PH_RUN = 2, PH_PARK = 3;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel_in;
  logic        hold;
  logic [31:0] tile_uo;

  logic [3:0] ena_a, rstn_a;
  logic [2:0] ena_b, rstn_b;
  logic [7:0] uo_a, uo_b;
  logic [1:0] sa_a, sa_b;
  logic       busy_a, busy_b;

  tile_select_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .hold(hold), .tile_uo(tile_uo),
    .tile_rst_n(rstn_a), .tile_ena(ena_a), .uo_out(uo_a), .sel_active(sa_a), .busy(busy_a)
  );

  tile_select_sequencer #(.NUM_TILES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel_in(sel_in), .hold(hold), .tile_uo(tile_uo[23:0]),
    .tile_rst_n(rstn_b), .tile_ena(ena_b), .uo_out(uo_b), .sel_active(sa_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: one shared debounced select, per-instance phase with cycles remaining.
  logic [1:0] m_hist[$];
  logic [1:0] m_stable;
  int         m_phase[2];
  int         m_left[2];
  logic [1:0] m_tgt[2];
  logic [1:0] m_act[2];
  logic [7:0] m_uo[2];

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < DB_WIN; i++) m_hist.push_back(2'd0);
    m_stable = 2'd0;
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = PH_DRAIN;
      m_left[k]  = RST_CYC;
      m_tgt[k]   = 2'd0;
      m_act[k]   = 2'd0;
      m_uo[k]    = 8'd0;
    end
  endtask

  task automatic start_drain(input int k);
    m_phase[k] = PH_DRAIN;
    m_left[k]  = RST_CYC;
    m_tgt[k]   = m_stable;
    m_uo[k]    = 8'd0;
  endtask

  task automatic model_step(input int k);
    int n;
    logic [31:0] t;
    n = (k == 0) ? 4 : 3;
    case (m_phase[k])
      PH_DRAIN: begin
        m_tgt[k] = m_stable;
        m_uo[k]  = 8'd0;
        m_left[k]--;
        if (m_left[k] == 0) begin
          if (int'(m_stable) < n) begin
            m_phase[k] = PH_REL;
            m_act[k]   = m_stable;
            m_left[k]  = (SETTLE_CYC > 0) ? SETTLE_CYC : 1;
          end else begin
            m_phase[k] = PH_PARK;
            m_act[k]   = 2'b11;
          end
        end
      end
      PH_REL: begin
        if (m_stable != m_tgt[k]) start_drain(k);
        else begin
          m_left[k]--;
          if (m_left[k] == 0) m_phase[k] = PH_RUN;
        end
      end
      PH_RUN: begin
        if (m_stable != m_act[k]) start_drain(k);
        else if (!hold) begin
          t = tile_uo >> (8 * m_act[k]);
          m_uo[k] = t[7:0];
        end
      end
      default: begin
        if (int'(m_stable) < n) start_drain(k);
      end
    endcase
  endtask

  // New select is accepted once the last STABLE_CYC+1 samples agree.
  task automatic debounce_step();
    logic same;
    same = 1'b1;
    for (int i = 1; i < m_hist.size(); i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
    if (same && (m_hist[0] != m_stable)) m_stable = m_hist[0];
    m_hist.push_back(sel_in);
    void'(m_hist.pop_front());
  endtask

  function automatic logic [31:0] exp_ena(input int k);
    if (m_phase[k] == PH_REL || m_phase[k] == PH_RUN) return 32'd1 << m_tgt[k];
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_busy(input int k);
    return (m_phase[k] == PH_DRAIN || m_phase[k] == PH_REL) ? 32'd1 : 32'd0;
  endfunction

  initial begin : compare_proc
    forever begin
      @(posedge clk);
      if (rst_n) begin
        model_step(0);
        model_step(1);
        debounce_step();
        #1;
        if (rst_n) begin
          chk("a_ena",    32'(ena_a),  exp_ena(0));
          chk("a_rst_n",  32'(rstn_a), exp_ena(0));
          chk("a_uo",     32'(uo_a),   32'(m_uo[0]));
          chk("a_sel",    32'(sa_a),   32'(m_act[0]));
          chk("a_busy",   32'(busy_a), exp_busy(0));
          chk("b_ena",    32'(ena_b),  exp_ena(1));
          chk("b_rst_n",  32'(rstn_b), exp_ena(1));
          chk("b_uo",     32'(uo_b),   32'(m_uo[1]));
          chk("b_sel",    32'(sa_b),   32'(m_act[1]));
          chk("b_busy",   32'(busy_b), exp_busy(1));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Cycle 1 is the cycle in which rst_n has just been released.
  task automatic bringup_checks();
    tick(7);
    chk("up8_busy", 32'(busy_a), 32'd1);
    chk("up8_ena",  32'(ena_a),  32'd0);
    chk("up8_uo",   32'(uo_a),   32'd0);
    tick(1);
    chk("up9_ena",  32'(ena_a),  32'b0001);
    chk("up9_rstn", 32'(rstn_a), 32'b0001);
    tick(2);
    chk("up11_busy", 32'(busy_a), 32'd0);
    tick(1);
    chk("up12_uo", 32'(uo_a), 32'hA5);
  endtask

  initial begin : stim_proc
    logic [1:0] prev;
    logic [1:0] v;
    int         dur;
    rst_n   = 1'b0;
    sel_in  = 2'd0;
    hold    = 1'b0;
    tile_uo = 32'h5A3C96A5;
    model_reset();
    tick(2);
    chk("rst_uo",   32'(uo_a),   32'd0);
    chk("rst_busy", 32'(busy_a), 32'd1);
    chk("rst_ena",  32'(ena_a),  32'd0);
    chk("rst_rstn", 32'(rstn_a), 32'd0);
    chk("rst_sel",  32'(sa_a),   32'd0);
    rst_n = 1'b1;
    bringup_checks();

    // Switch 0 -> 2
    tick(3);
    sel_in = 2'd2;
    tick(6);
    chk("sw6_ena", 32'(ena_a), 32'b0001);
    tick(1);
    chk("sw7_ena", 32'(ena_a), 32'd0);
    chk("sw7_uo",  32'(uo_a),  32'd0);
    tick(8);
    chk("sw15_ena", 32'(ena_a), 32'b0100);
    chk("sw15_sel", 32'(sa_a),  32'd2);
    tick(3);
    chk("sw18_uo", 32'(uo_a), 32'h3C);

    // Glitch reject
    tick(2);
    sel_in = 2'd1;
    tick(3);
    sel_in = 2'd2;
    tick(10);
    chk("gl_busy", 32'(busy_a), 32'd0);
    chk("gl_uo",   32'(uo_a),   32'h3C);

    // Abort from RELEASE; 3-tile instance parks on select 3
    sel_in = 2'd1;
    tick(10);
    sel_in = 2'd3;
    tick(5);
    chk("ab15_ena", 32'(ena_a), 32'b0010);
    tick(1);
    chk("ab16_ena", 32'(ena_a), 32'b0010);
    tick(1);
    chk("ab17_ena",  32'(ena_a),  32'd0);
    chk("ab17_busy", 32'(busy_a), 32'd1);
    tick(8);
    chk("ab25_ena",   32'(ena_a),  32'b1000);
    chk("ab25_sel",   32'(sa_a),   32'd3);
    chk("park_sel",   32'(sa_b),   32'b11);
    chk("park_busy",  32'(busy_b), 32'd0);
    chk("park_ena",   32'(ena_b),  32'd0);
    tick(2);
    chk("ab27_busy", 32'(busy_a), 32'd0);

    sel_in = 2'd1;
    tick(30);
    chk("unpark_sel",  32'(sa_b),   32'd1);
    chk("unpark_busy", 32'(busy_b), 32'd0);
    chk("unpark_ena",  32'(ena_b),  32'b010);

    // Hold freezes uo_out
    hold    = 1'b1;
    tile_uo = 32'h5A3C77A5;
    tick(3);
    chk("hold_uo", 32'(uo_a), 32'h96);
    hold = 1'b0;
    tick(2);
    chk("unhold_uo", 32'(uo_a), 32'h77);

    // Retarget mid-DRAIN without stretching it
    sel_in = 2'd0;
    tick(7);
    chk("md7_ena", 32'(ena_a), 32'd0);
    sel_in = 2'd2;
    tick(7);
    chk("md14_ena", 32'(ena_a), 32'd0);
    tick(1);
    chk("md15_ena", 32'(ena_a), 32'b0100);
    chk("md15_sel", 32'(sa_a),  32'd2);
    tick(4);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_ena",  32'(ena_a),  32'd0);
    chk("ar_rstn", 32'(rstn_a), 32'd0);
    chk("ar_uo",   32'(uo_a),   32'd0);
    sel_in  = 2'd0;
    tile_uo = 32'h5A3C96A5;
    tick(2);
    rst_n = 1'b1;
    bringup_checks();

    // Random: runs are either short glitches (1..3) or long holds (>=8)
    prev = 2'd0;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        sel_in = 2'($urandom_range(0, 3));
        dur = $urandom_range(1, 3);
        for (int c = 0; c < dur; c++) begin
          tile_uo = $urandom;
          hold    = ($urandom_range(0, 3) == 0);
          tick(1);
        end
      end
      v      = 2'($urandom_range(0, 3));
      sel_in = v;
      prev   = v;
      dur    = $urandom_range(8, 40);
      for (int c = 0; c < dur; c++) begin
        tile_uo = $urandom;
        hold    = ($urandom_range(0, 3) == 0);
        tick(1);
      end
    end
    hold = 1'b0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
